// File: rtl/flash_cmd_pkg.sv
// Shared types and the JEDEC unlock/command sequence table for the parallel-flash command sequencer.
package flash_cmd_pkg;

    typedef enum logic [1:0] {
        OP_PROG   = 2'd0,
        OP_SECTOR = 2'd1,
        OP_CHIP   = 2'd2,
        OP_RSVD   = 2'd3
    } op_e;

    typedef enum logic [1:0] {IDLE, WRITE, POLL, FINISH} top_state_e;

    typedef enum logic [2:0] {
        B_IDLE, W_SETUP, W_PULSE, W_HOLD, W_GAP, P_READ, P_EVAL
    } bus_state_e;

    typedef enum logic [1:0] {SEL_U1, SEL_U2, SEL_SECTOR, SEL_TARGET} addr_sel_e;

    localparam logic [7:0] CMD_AA = 8'hAA;
    localparam logic [7:0] CMD_55 = 8'h55;
    localparam logic [7:0] CMD_A0 = 8'hA0;
    localparam logic [7:0] CMD_80 = 8'h80;
    localparam logic [7:0] CMD_30 = 8'h30;
    localparam logic [7:0] CMD_10 = 8'h10;

    localparam logic [18:0] UNLOCK1_DEF = 19'h05555;
    localparam logic [18:0] UNLOCK2_DEF = 19'h02AAA;

    typedef struct packed {
        addr_sel_e  sel;
        logic [7:0] data;
    } seq_step_t;

    function automatic logic [2:0] seq_last(input op_e op);
        return (op == OP_PROG) ? 3'd3 : 3'd5;
    endfunction

    // SEL_TARGET steps carry the host byte; the data field is a don't-care there.
    function automatic seq_step_t seq_lookup(input op_e op, input logic [2:0] step);
        seq_step_t s;
        s.sel  = SEL_U1;
        s.data = CMD_AA;
        case (step)
            3'd1: begin s.sel = SEL_U2; s.data = CMD_55; end
            3'd2: s.data = (op == OP_PROG) ? CMD_A0 : CMD_80;
            3'd3: begin
                if (op == OP_PROG) begin
                    s.sel  = SEL_TARGET;
                    s.data = 8'h00;
                end
            end
            3'd4: begin s.sel = SEL_U2; s.data = CMD_55; end
            3'd5: begin
                if (op == OP_SECTOR) begin
                    s.sel  = SEL_SECTOR;
                    s.data = CMD_30;
                end else begin
                    s.data = CMD_10;
                end
            end
            default: ;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/flash_bus_cycle.sv
// One flash bus cycle (timed write strobe or DQ7 poll read), with chaining of back-to-back cycles.
module flash_bus_cycle
    import flash_cmd_pkg::*;
#(
    parameter int T_SETUP = 1,
    parameter int T_WP    = 3,
    parameter int T_RD    = 3
) (
    input  logic        fast_clock,
    input  logic        reset,
    input  logic        start,
    input  logic        rw,
    input  logic [18:0] addr,
    input  logic [7:0]  wdata,
    output logic        cycle_done,
    output logic [7:0]  rdata,
    output logic        _ce_flash,
    output logic        _oe_flash,
    output logic        _we_flash,
    output logic [18:0] baddress,
    inout  wire  [7:0]  bdata
);

    localparam logic [3:0] SETUP_LAST = 4'(T_SETUP - 1);
    localparam logic [3:0] WP_LAST    = 4'(T_WP - 1);
    localparam logic [3:0] RD_LAST    = 4'(T_RD - 1);

    bus_state_e state_q, state_d;
    logic [3:0] cnt_q;
    logic [7:0] wdata_q;
    logic       launch;
    logic       drive;

    always_ff @(posedge fast_clock) begin
        if (reset) state_q <= B_IDLE;
        else       state_q <= state_d;
    end

    // A new cycle may launch straight out of W_GAP/P_EVAL so cycles chain without idle clocks.
    always_comb begin
        state_d = state_q;
        launch  = 1'b0;
        case (state_q)
            B_IDLE, W_GAP, P_EVAL: begin
                state_d = B_IDLE;
                if (start) begin
                    launch  = 1'b1;
                    state_d = rw ? P_READ : W_SETUP;
                end
            end
            W_SETUP: if (cnt_q == SETUP_LAST) state_d = W_PULSE;
            W_PULSE: if (cnt_q == WP_LAST)    state_d = W_HOLD;
            W_HOLD:  state_d = W_GAP;
            P_READ:  if (cnt_q == RD_LAST)    state_d = P_EVAL;
            default: state_d = B_IDLE;
        endcase
    end

    always_comb begin
        _ce_flash  = !(state_q inside {W_SETUP, W_PULSE, W_HOLD, P_READ});
        _we_flash  = (state_q != W_PULSE);
        _oe_flash  = (state_q != P_READ);
        drive      = (state_q inside {W_SETUP, W_PULSE, W_HOLD});
        cycle_done = (state_q inside {W_GAP, P_EVAL});
    end

    always_ff @(posedge fast_clock) begin
        cnt_q <= (state_d != state_q) ? 4'd0 : cnt_q + 4'd1;
        if (launch) wdata_q <= wdata;
        if (state_q == P_READ && cnt_q == RD_LAST) rdata <= bdata;
    end

    always_ff @(posedge fast_clock) begin
        if (reset)       baddress <= '0;
        else if (launch) baddress <= addr;
    end

    assign bdata = drive ? wdata_q : 8'bz;

endmodule

// File: rtl/flash_cmd_sequencer.sv
// Turns program / sector-erase / chip-erase requests into JEDEC command sequences and completes them by DQ7 polling.
module flash_cmd_sequencer
    import flash_cmd_pkg::*;
#(
    parameter int          T_SETUP   = 1,
    parameter int          T_WP      = 3,
    parameter int          T_RD      = 3,
    parameter int          TIMEOUT_W = 20,
    parameter logic [18:0] UNLOCK1   = UNLOCK1_DEF,
    parameter logic [18:0] UNLOCK2   = UNLOCK2_DEF
) (
    input  logic        fast_clock,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [1:0]  req_op,
    input  logic [18:0] req_addr,
    input  logic [7:0]  req_data,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic        _ce_flash,
    output logic        _oe_flash,
    output logic        _we_flash,
    output logic [18:0] baddress,
    inout  wire  [7:0]  bdata
);

    top_state_e           state_q, state_d;
    op_e                  op_q;
    logic [18:0]          addr_q;
    logic [7:0]           data_q;
    logic [2:0]           step_q, step_nxt;
    logic [TIMEOUT_W-1:0] poll_cnt_q, poll_cnt_inc;
    logic                 fail_q, fail_d;
    logic                 start, rw, step_adv, poll_adv;
    logic [18:0]          cyc_addr, poll_addr;
    logic [7:0]           cyc_wdata, rdata;
    logic                 cycle_done, exp_dq7;
    seq_step_t            first, nxt;

    function automatic logic [18:0] sel_addr(input addr_sel_e sel, input logic [18:0] target);
        case (sel)
            SEL_U1:     return UNLOCK1;
            SEL_U2:     return UNLOCK2;
            SEL_SECTOR: return {target[18:12], 12'h000};
            default:    return target;
        endcase
    endfunction

    assign step_nxt     = step_q + 3'd1;
    assign poll_cnt_inc = poll_cnt_q + TIMEOUT_W'(1);
    assign first        = seq_lookup(op_e'(req_op), 3'd0);
    assign nxt          = seq_lookup(op_q, step_nxt);
    assign exp_dq7      = (op_q == OP_PROG) ? data_q[7] : 1'b1;
    assign poll_addr    = (op_q == OP_PROG)   ? addr_q :
                          (op_q == OP_SECTOR) ? {addr_q[18:12], 12'h000} : 19'h0;

    always_ff @(posedge fast_clock) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // The first write is launched on the accept edge so the bus is busy the very next clock.
    always_comb begin
        state_d   = state_q;
        fail_d    = fail_q;
        start     = 1'b0;
        rw        = 1'b0;
        cyc_addr  = UNLOCK1;
        cyc_wdata = CMD_AA;
        step_adv  = 1'b0;
        poll_adv  = 1'b0;
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    if (op_e'(req_op) == OP_RSVD) begin
                        state_d = FINISH;
                        fail_d  = 1'b1;
                    end else begin
                        state_d   = WRITE;
                        start     = 1'b1;
                        cyc_addr  = sel_addr(first.sel, req_addr);
                        cyc_wdata = first.data;
                    end
                end
            end
            WRITE: begin
                if (cycle_done) begin
                    start = 1'b1;
                    if (step_q == seq_last(op_q)) begin
                        rw       = 1'b1;
                        cyc_addr = poll_addr;
                        state_d  = POLL;
                    end else begin
                        step_adv  = 1'b1;
                        cyc_addr  = sel_addr(nxt.sel, addr_q);
                        cyc_wdata = (nxt.sel == SEL_TARGET) ? data_q : nxt.data;
                    end
                end
            end
            POLL: begin
                if (cycle_done) begin
                    if (rdata[7] == exp_dq7) begin
                        state_d = FINISH;
                        fail_d  = 1'b0;
                    end else if (&poll_cnt_inc) begin
                        state_d = FINISH;
                        fail_d  = 1'b1;
                    end else begin
                        start    = 1'b1;
                        rw       = 1'b1;
                        cyc_addr = poll_addr;
                        poll_adv = 1'b1;
                    end
                end
            end
            FINISH: state_d = IDLE;
        endcase
    end

    always_comb begin
        req_ready = (state_q == IDLE);
        busy      = (state_q != IDLE);
        done      = (state_q == FINISH) && !fail_q;
        err       = (state_q == FINISH) && fail_q;
    end

    always_ff @(posedge fast_clock) begin
        if (reset) begin
            step_q     <= '0;
            poll_cnt_q <= '0;
            fail_q     <= 1'b0;
        end else begin
            fail_q <= fail_d;
            if (state_q == IDLE) begin
                step_q     <= '0;
                poll_cnt_q <= '0;
            end else begin
                if (step_adv) step_q     <= step_nxt;
                if (poll_adv) poll_cnt_q <= poll_cnt_inc;
            end
        end
    end

    always_ff @(posedge fast_clock) begin
        if (state_q == IDLE && req_valid) begin
            op_q   <= op_e'(req_op);
            addr_q <= req_addr;
            data_q <= req_data;
        end
    end

    flash_bus_cycle #(
        .T_SETUP (T_SETUP),
        .T_WP    (T_WP),
        .T_RD    (T_RD)
    ) u_bus (
        .fast_clock (fast_clock),
        .reset      (reset),
        .start      (start),
        .rw         (rw),
        .addr       (cyc_addr),
        .wdata      (cyc_wdata),
        .cycle_done (cycle_done),
        .rdata      (rdata),
        ._ce_flash  (_ce_flash),
        ._oe_flash  (_oe_flash),
        ._we_flash  (_we_flash),
        .baddress   (baddress),
        .bdata      (bdata)
    );

endmodule
